dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store path (port 0) and the encryption coprocessor DMA (port 1).
- Round-robin arbitration with bounded bus locking, so the coprocessor can stream key/state blocks.
- Returns registered read data tagged to the winning requester.
- Sits between the core/coprocessor and the data RAM, which has a 1-cycle synchronous read.

---
 rtl/dmem_port_arbiter_pkg.sv | 18 +
 rtl/dmem_port_arbiter_if.sv | 33 +++
 rtl/dmem_port_arbiter_rr_pick2.sv | 15 +
 rtl/dmem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int unsigned PORT_CORE        = 0;
    localparam int unsigned PORT_COP         = 1;
    localparam int unsigned DEFAULT_MAX_LOCK = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter; slave is the arbiter view.
interface dmem_port_arbiter_if #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TRANSFER_WIDTH = 4
);
    logic [1:0]                  req_i;
    logic [1:0]                  lock_i;
    logic [1:0]                  we_i;
    logic [2*MEM_ADDR_WIDTH-1:0] addr_i;
    logic [2*DATA_WIDTH-1:0]     wdata_i;
    logic [2*TRANSFER_WIDTH-1:0] be_i;
    logic [1:0]                  gnt_o;
    logic [1:0]                  rvalid_o;
    logic [DATA_WIDTH-1:0]       rdata_o;
    logic                        mem_en_o;
    logic                        mem_we_o;
    logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]       mem_wdata_o;
    logic [TRANSFER_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0]       mem_rdata_i;

    modport slave (
        input  req_i, lock_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output req_i, lock_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

endinterface

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with bounded bus locking sharing one data-RAM port between core and DMA.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TRANSFER_WIDTH = 4,
    parameter int unsigned MAX_LOCK       = DEFAULT_MAX_LOCK
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
);

    localparam logic [7:0] LockMax = 8'(MAX_LOCK);

    arb_state_e r_state, w_state_d;
    logic       r_last_gnt, w_last_d;
    logic [7:0] r_lock_cnt, w_cnt_d;
    logic [1:0] r_rd_tag;

    logic [1:0] w_rr_gnt;
    logic [1:0] w_gnt;
    logic       w_own;

    logic                      w_mem_en;
    logic                      w_mem_we;
    logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]     w_mem_wdata;
    logic [TRANSFER_WIDTH-1:0] w_mem_be;

    rr_pick2 u_pick (
        .i_req  (bus.req_i),
        .i_last (r_last_gnt),
        .o_gnt  (w_rr_gnt)
    );

    assign w_own = (r_state == ARB_OWN1);

    always_comb begin
        w_gnt     = 2'b00;
        w_state_d = r_state;
        w_last_d  = r_last_gnt;
        w_cnt_d   = r_lock_cnt;
        case (r_state)
            ARB_IDLE: begin
                w_gnt = w_rr_gnt;
                if (w_rr_gnt[PORT_CORE]) begin
                    w_last_d = 1'b0;
                    if (bus.lock_i[PORT_CORE]) begin
                        w_state_d = ARB_OWN0;
                        w_cnt_d   = 8'd1;
                    end
                end else if (w_rr_gnt[PORT_COP]) begin
                    w_last_d = 1'b1;
                    if (bus.lock_i[PORT_COP]) begin
                        w_state_d = ARB_OWN1;
                        w_cnt_d   = 8'd1;
                    end
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                // Forced release takes priority: the owner loses this cycle, other port wins next.
                if ((r_lock_cnt == LockMax) && bus.req_i[~w_own]) begin
                    w_state_d = ARB_IDLE;
                    w_last_d  = w_own;
                end else if (bus.req_i[w_own]) begin
                    w_gnt    = port_onehot(w_own);
                    w_last_d = w_own;
                    if (r_lock_cnt != LockMax) begin
                        w_cnt_d = r_lock_cnt + 8'd1;
                    end
                    if (!bus.lock_i[w_own]) begin
                        w_state_d = ARB_IDLE;
                    end
                end else if (!bus.lock_i[w_own]) begin
                    w_state_d = ARB_IDLE;
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase
    end

    // Only the granted port's fields reach the RAM, so unrequested X inputs stay contained.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_be    = '0;
        case (w_gnt)
            2'b01: begin
                w_mem_en    = 1'b1;
                w_mem_we    = bus.we_i[0];
                w_mem_addr  = bus.addr_i[0 +: MEM_ADDR_WIDTH];
                w_mem_wdata = bus.wdata_i[0 +: DATA_WIDTH];
                w_mem_be    = bus.be_i[0 +: TRANSFER_WIDTH];
            end
            2'b10: begin
                w_mem_en    = 1'b1;
                w_mem_we    = bus.we_i[1];
                w_mem_addr  = bus.addr_i[MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                w_mem_wdata = bus.wdata_i[DATA_WIDTH +: DATA_WIDTH];
                w_mem_be    = bus.be_i[TRANSFER_WIDTH +: TRANSFER_WIDTH];
            end
            default: begin
                w_mem_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
            r_lock_cnt <= 8'd0;
            r_rd_tag   <= 2'b00;
        end else begin
            r_state    <= w_state_d;
            r_last_gnt <= w_last_d;
            r_lock_cnt <= w_cnt_d;
            r_rd_tag   <= w_gnt & {2{~w_mem_we}};
        end
    end

    assign bus.gnt_o       = w_gnt;
    // Masking with rst drops a read whose data would land in the reset cycle.
    assign bus.rvalid_o    = r_rd_tag & {2{~rst}};
    assign bus.rdata_o     = bus.mem_rdata_i;
    assign bus.mem_en_o    = w_mem_en;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;
    assign bus.mem_be_o    = w_mem_be;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 1-cycle-read RAM.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(
        .MEM_ADDR_WIDTH (10),
        .DATA_WIDTH     (32),
        .TRANSFER_WIDTH (4),
        .MAX_LOCK       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    logic [31:0] ram_q;

    always @(posedge clk) begin
        if (rst) begin
            ram[10'h010] <= 32'hDEADBEEF;
            ram[10'h020] <= 32'h11223344;
            ram[10'h030] <= 32'h30303030;
            ram[10'h031] <= 32'h31313131;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.mem_be_o[k]) ram[bus.mem_addr_o][8*k +: 8] <= bus.mem_wdata_o[8*k +: 8];
                end
            end else begin
                ram_q <= ram[bus.mem_addr_o];
            end
        end
    end
    assign bus.mem_rdata_i = ram_q;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] wd0;
        logic [3:0]  be0;
        logic [1:0]  gnt;
        logic [9:0]  maddr;
        logic [1:0]  rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [3:0] be0, input logic [3:0] be1);
        bus.req_i   = req;
        bus.lock_i  = lock;
        bus.we_i    = we;
        bus.addr_i  = {a1, a0};
        bus.wdata_i = {wd1, wd0};
        bus.be_i    = {be1, be0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] burst_exp [15];
    int         b;
    int         ncyc;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);

        // 11: tie alternates starting with core; 5-6: single read; 7-9: byte-masked write then read
        vecs[0] = '{2'b11, 2'b00, 10'h030, 10'h031, 32'h0, 4'hF, 2'b01, 10'h030, 2'b00, 32'h0};
        vecs[1] = '{2'b11, 2'b00, 10'h030, 10'h031, 32'h0, 4'hF, 2'b10, 10'h031, 2'b01, 32'h30303030};
        vecs[2] = '{2'b11, 2'b00, 10'h030, 10'h031, 32'h0, 4'hF, 2'b01, 10'h030, 2'b10, 32'h31313131};
        vecs[3] = '{2'b11, 2'b00, 10'h030, 10'h031, 32'h0, 4'hF, 2'b10, 10'h031, 2'b01, 32'h30303030};
        vecs[4] = '{2'b00, 2'b00, 10'h030, 10'h031, 32'h0, 4'hF, 2'b00, 10'h000, 2'b10, 32'h31313131};
        vecs[5] = '{2'b01, 2'b00, 10'h010, 10'h031, 32'h0, 4'hF, 2'b01, 10'h010, 2'b00, 32'h0};
        vecs[6] = '{2'b00, 2'b00, 10'h010, 10'h031, 32'h0, 4'hF, 2'b00, 10'h000, 2'b01, 32'hDEADBEEF};
        vecs[7] = '{2'b01, 2'b01, 10'h020, 10'h031, 32'hA5A5A5A5, 4'b0011, 2'b01, 10'h020, 2'b00, 32'h0};
        vecs[8] = '{2'b01, 2'b00, 10'h020, 10'h031, 32'h0, 4'hF, 2'b01, 10'h020, 2'b00, 32'h0};
        vecs[9] = '{2'b00, 2'b00, 10'h020, 10'h031, 32'h0, 4'hF, 2'b00, 10'h000, 2'b01, 32'h1122A5A5};

        for (int i = 0; i < 15; i++) burst_exp[i] = 2'b10;
        burst_exp[8]  = 2'b00;
        burst_exp[9]  = 2'b01;
        burst_exp[14] = 2'b01;

        step();
        #4;
        chk("reset_gnt", 64'(bus.gnt_o), 64'(2'b00));
        chk("reset_mem_en", 64'(bus.mem_en_o), 64'(1'b0));
        step();
        rst = 1'b0;
        #4;
        chk("reset_rvalid", 64'(bus.rvalid_o), 64'(2'b00));
        chk("reset_state", 64'(dut.r_state), 64'(ARB_IDLE));
        step();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].req, 2'b00, vecs[i].we, vecs[i].a0, vecs[i].a1,
                  vecs[i].wd0, 32'h0, vecs[i].be0, 4'hF);
            #4;
            chk($sformatf("vec%0d_gnt", i), 64'(bus.gnt_o), 64'(vecs[i].gnt));
            chk($sformatf("vec%0d_mem_en", i), 64'(bus.mem_en_o), 64'(|vecs[i].gnt));
            chk($sformatf("vec%0d_mem_addr", i), 64'(bus.mem_addr_o), 64'(vecs[i].maddr));
            chk($sformatf("vec%0d_rvalid", i), 64'(bus.rvalid_o), 64'(vecs[i].rv));
            if (vecs[i].rv != 2'b00) begin
                chk($sformatf("vec%0d_rdata", i), 64'(bus.rdata_o), 64'(vecs[i].rd));
            end
            step();
        end

        // Locked DMA write burst with core contending; last winner is core so DMA takes the tie.
        b = 0;
        for (int c = 0; c < 15; c++) begin
            drive({(b < 12) ? 1'b1 : 1'b0, 1'b1}, {(b < 11) ? 1'b1 : 1'b0, 1'b0}, 2'b10,
                  10'h010, 10'(10'h100 + b), 32'h0, 32'hC0DE0000 + 32'(b), 4'hF, 4'hF);
            #4;
            chk($sformatf("burst_c%0d_gnt", c), 64'(bus.gnt_o), 64'(burst_exp[c]));
            if (burst_exp[c] == 2'b10) begin
                chk($sformatf("burst_c%0d_addr", c), 64'(bus.mem_addr_o), 64'(10'h100 + b));
            end
            if (bus.gnt_o[1]) b++;
            step();
        end
        chk("burst_beats", 64'(b), 64'(12));
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        step();
        chk("burst_ram_first", 64'(ram[10'h100]), 64'(32'hC0DE0000));
        chk("burst_ram_last", 64'(ram[10'h10B]), 64'(32'hC0DE000B));

        // Uncontended locked burst runs past MAX_LOCK with a saturated counter.
        b    = 0;
        ncyc = 0;
        while (b < 12 && ncyc < 20) begin
            drive(2'b10, {(b < 11) ? 1'b1 : 1'b0, 1'b0}, 2'b10, 10'h0, 10'(10'h200 + b),
                  32'h0, 32'hBEEF0000 + 32'(b), 4'hF, 4'hF);
            #4;
            chk($sformatf("solo_b%0d_gnt", b), 64'(bus.gnt_o), 64'(2'b10));
            if (bus.gnt_o[1]) b++;
            ncyc++;
            step();
        end
        chk("solo_cycles", 64'(ncyc), 64'(12));
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        #4;
        chk("solo_state_idle", 64'(dut.r_state), 64'(ARB_IDLE));
        step();
        chk("solo_ram_last", 64'(ram[10'h20B]), 64'(32'hBEEF000B));

        // Core read, then reset before its data returns.
        drive(2'b01, 2'b00, 2'b00, 10'h010, 10'h0, 32'h0, 32'h0, 4'hF, 4'hF);
        #4;
        chk("rst_rd_gnt", 64'(bus.gnt_o), 64'(2'b01));
        step();
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        #4;
        chk("rst_rvalid_dropped", 64'(bus.rvalid_o), 64'(2'b00));
        step();
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 10'h030, 10'h031, 32'h0, 32'h0, 4'hF, 4'hF);
        #4;
        chk("rst_after_rvalid", 64'(bus.rvalid_o), 64'(2'b00));
        chk("rst_after_state", 64'(dut.r_state), 64'(ARB_IDLE));
        chk("rst_tie_core", 64'(bus.gnt_o), 64'(2'b01));
        step();
        drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        #4;
        chk("rst_reread_rvalid", 64'(bus.rvalid_o), 64'(2'b01));
        chk("rst_reread_rdata", 64'(bus.rdata_o), 64'(32'h30303030));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
